// File: rtl/rv32i_instr_encoder.sv
// RV32I instruction encoder: turns (class, op, regs, imm) requests into instruction words queued in a FIFO.
// Optional feature macro: RV32I_ENC_IMM_CHECK_EN (immediate range checking; illegal on failure).
module rv32i_instr_encoder #(
    parameter int DEPTH         = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic [2:0]               req_class_i,
    input  logic [3:0]               req_op_i,
    input  logic [4:0]               req_rd_i,
    input  logic [4:0]               req_rs1_i,
    input  logic [4:0]               req_rs2_i,
    input  logic [31:0]              req_imm_i,
    output logic                     instr_valid_o,
    input  logic                     instr_ready_i,
    output logic [31:0]              instr_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     err_o,
    output logic [ERR_CNT_WIDTH-1:0] err_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] L_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] L_ONE  = (AW + 1)'(1);
    localparam logic [AW:0] L_ZERO = (AW + 1)'(0);
    localparam logic [ERR_CNT_WIDTH-1:0] C_ONE = ERR_CNT_WIDTH'(1);

    localparam logic [6:0] OPC_ALU    = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    logic [31:0]         r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [AW:0]         r_level;
    logic                r_err;
    logic [ERR_CNT_WIDTH-1:0] r_err_cnt;

    logic [2:0]  w_f3_alu;
    logic [6:0]  w_f7_alu;
    logic        w_op_ok;
    logic        w_is_shift;
    logic [2:0]  w_f3;
    logic [31:0] w_word;
    logic        w_legal;
    logic        w_imm_i_ok;
    logic        w_imm_b_ok;
    logic        w_imm_u_ok;
    logic        w_imm_sh_ok;
    logic        w_full;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

`ifdef RV32I_ENC_IMM_CHECK_EN
    assign w_imm_i_ok  = (&req_imm_i[31:11]) | ~(|req_imm_i[31:11]);
    assign w_imm_b_ok  = ((&req_imm_i[31:12]) | ~(|req_imm_i[31:12])) & ~req_imm_i[0];
    assign w_imm_u_ok  = ~(|req_imm_i[11:0]);
    assign w_imm_sh_ok = ~(|req_imm_i[31:5]);
`else
    assign w_imm_i_ok  = 1'b1;
    assign w_imm_b_ok  = 1'b1;
    assign w_imm_u_ok  = 1'b1;
    assign w_imm_sh_ok = 1'b1;
`endif

    assign w_f3       = req_op_i[2:0];
    assign w_is_shift = (req_op_i == 4'd2) | (req_op_i == 4'd6) | (req_op_i == 4'd7);

    // ALU operation index to funct3/funct7
    always_comb begin
        w_f3_alu = 3'b000;
        w_f7_alu = 7'b0000000;
        w_op_ok  = 1'b1;
        case (req_op_i)
            4'd0:    w_f3_alu = 3'b000;
            4'd1:    begin w_f3_alu = 3'b000; w_f7_alu = 7'b0100000; end
            4'd2:    w_f3_alu = 3'b001;
            4'd3:    w_f3_alu = 3'b010;
            4'd4:    w_f3_alu = 3'b011;
            4'd5:    w_f3_alu = 3'b100;
            4'd6:    w_f3_alu = 3'b101;
            4'd7:    begin w_f3_alu = 3'b101; w_f7_alu = 7'b0100000; end
            4'd8:    w_f3_alu = 3'b110;
            4'd9:    w_f3_alu = 3'b111;
            default: w_op_ok  = 1'b0;
        endcase
    end

    // Instruction word assembly and legality per class
    always_comb begin
        w_word  = 32'h0000_0000;
        w_legal = 1'b0;
        case (req_class_i)
            3'd0: begin
                w_word  = {w_f7_alu, req_rs2_i, req_rs1_i, w_f3_alu, req_rd_i, OPC_ALU};
                w_legal = w_op_ok;
            end
            3'd1: begin
                if (w_is_shift) begin
                    w_word  = {w_f7_alu, req_imm_i[4:0], req_rs1_i, w_f3_alu, req_rd_i, OPC_IMM};
                    w_legal = w_imm_sh_ok;
                end else begin
                    w_word  = {req_imm_i[11:0], req_rs1_i, w_f3_alu, req_rd_i, OPC_IMM};
                    w_legal = w_op_ok & (req_op_i != 4'd1) & w_imm_i_ok;
                end
            end
            3'd2: begin
                w_word  = {req_imm_i[11:0], req_rs1_i, w_f3, req_rd_i, OPC_LOAD};
                w_legal = (w_f3 != 3'b011) & (w_f3 != 3'b110) & (w_f3 != 3'b111) & w_imm_i_ok;
            end
            3'd3: begin
                w_word  = {req_imm_i[11:5], req_rs2_i, req_rs1_i, w_f3, req_imm_i[4:0], OPC_STORE};
                w_legal = (w_f3 <= 3'b010) & w_imm_i_ok;
            end
            3'd4: begin
                w_word  = {req_imm_i[12], req_imm_i[10:5], req_rs2_i, req_rs1_i, w_f3,
                           req_imm_i[4:1], req_imm_i[11], OPC_BRANCH};
                w_legal = (w_f3 != 3'b010) & (w_f3 != 3'b011) & w_imm_b_ok;
            end
            3'd5: begin
                w_word  = {req_imm_i[31:12], req_rd_i, OPC_LUI};
                w_legal = w_imm_u_ok;
            end
            3'd6: begin
                w_word  = {req_imm_i[31:12], req_rd_i, OPC_AUIPC};
                w_legal = w_imm_u_ok;
            end
            default: begin
                w_word  = 32'h0000_0000;
                w_legal = 1'b0;
            end
        endcase
    end

    // No push-through when full: ready depends only on the registered level
    assign w_full      = (r_level == L_FULL);
    assign req_ready_o = ~rst_i & ~w_full;
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_push      = w_accept & w_legal;
    assign w_pop       = (r_level != L_ZERO) & instr_ready_i;

    // FIFO storage; contents need no reset since level gates visibility
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_word;
        end
    end

    // FIFO pointers, occupancy and illegal-request tracking
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_level   <= L_ZERO;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + L_ONE;
                2'b01:   r_level <= r_level - L_ONE;
                default: r_level <= r_level;
            endcase
            r_err <= w_accept & ~w_legal;
            if (w_accept & ~w_legal & ~(&r_err_cnt)) begin
                r_err_cnt <= r_err_cnt + C_ONE;
            end
        end
    end

    assign instr_valid_o = (r_level != L_ZERO);
    assign instr_o       = instr_valid_o ? r_mem[r_rptr] : 32'h0000_0000;
    assign level_o       = r_level;
    assign err_o         = r_err;
    assign err_cnt_o     = r_err_cnt;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Self-checking bench for rv32i_instr_encoder: directed spec cases plus randomized traffic
// against a queue-based reference model.
module tb_rv32i_instr_encoder;
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_class_i;
    logic [3:0]  req_op_i;
    logic [4:0]  req_rd_i;
    logic [4:0]  req_rs1_i;
    logic [4:0]  req_rs2_i;
    logic [31:0] req_imm_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [2:0]  level_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    int          exp_cnt = 0;
    bit          exp_err = 1'b0;

    localparam int F3TAB [10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};
    localparam int OPCTAB [8] = '{'h33, 'h13, 'h03, 'h23, 'h63, 'h37, 'h17, 0};

    rv32i_instr_encoder #(.DEPTH(DEPTH), .ERR_CNT_WIDTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_class_i(req_class_i), .req_op_i(req_op_i),
        .req_rd_i(req_rd_i), .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i),
        .req_imm_i(req_imm_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .level_o(level_o),
        .err_o(err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic bit model_legal(input int cls, input int op, input logic [31:0] imm);
        int  f3 = op % 8;
        int  s  = int'(imm);
        bit  shift = (op == 2 || op == 6 || op == 7);
        bit  ok;
        bit  i_ok  = 1'b1;
        bit  b_ok  = 1'b1;
        bit  u_ok  = 1'b1;
        bit  sh_ok = 1'b1;
`ifdef RV32I_ENC_IMM_CHECK_EN
        i_ok  = (s >= -2048) && (s <= 2047);
        b_ok  = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
        u_ok  = (imm % 4096) == 0;
        sh_ok = imm < 32;
`endif
        case (cls)
            0:       ok = op <= 9;
            1:       ok = shift ? sh_ok : (op <= 9 && op != 1 && i_ok);
            2:       ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) && i_ok;
            3:       ok = (f3 <= 2) && i_ok;
            4:       ok = (f3 != 2 && f3 != 3) && b_ok;
            5, 6:    ok = u_ok;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] model_word(input int cls, input int op, input int rd,
                                               input int rs1, input int rs2, input logic [31:0] imm);
        logic [31:0] w   = 32'(OPCTAB[cls]);
        int          f3  = (cls <= 1) ? ((op <= 9) ? F3TAB[op] : 0) : op % 8;
        int          f7  = (op == 1 || op == 7) ? 32 : 0;
        logic [31:0] rdf = 32'(rd) << 7;
        logic [31:0] r1f = 32'(rs1) << 15;
        logic [31:0] r2f = 32'(rs2) << 20;
        logic [31:0] f3f = 32'(f3) << 12;
        case (cls)
            0: w = w | rdf | f3f | r1f | r2f | (32'(f7) << 25);
            1: begin
                if (op == 2 || op == 6 || op == 7)
                    w = w | rdf | f3f | r1f | ((imm % 32) << 20) | (32'(f7) << 25);
                else
                    w = w | rdf | f3f | r1f | ((imm % 4096) << 20);
            end
            2: w = w | rdf | f3f | r1f | ((imm % 4096) << 20);
            3: w = w | ((imm % 32) << 7) | f3f | r1f | r2f | (((imm / 32) % 128) << 25);
            4: w = w | (((imm / 2048) % 2) << 7) | (((imm / 2) % 16) << 8) | f3f | r1f | r2f
                     | (((imm / 32) % 64) << 25) | (((imm / 4096) % 2) << 31);
            5, 6: w = w | rdf | (imm / 4096 * 4096);
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    // One clock of stimulus with full model update and output comparison
    task automatic cycle(input bit rst, input bit v, input int cls, input int op, input int rd,
                         input int rs1, input int rs2, input logic [31:0] imm, input bit rdy);
        bit          exp_ready, acc, pop, leg;
        logic [31:0] w;
        rst_i = rst; req_valid_i = v; req_class_i = 3'(cls); req_op_i = 4'(op);
        req_rd_i = 5'(rd); req_rs1_i = 5'(rs1); req_rs2_i = 5'(rs2); req_imm_i = imm;
        instr_ready_i = rdy;
        #1;
        exp_ready = !rst && (q.size() < DEPTH);
        chk("req_ready", 32'(req_ready_o), 32'(exp_ready));
        acc = v && exp_ready;
        pop = !rst && (q.size() > 0) && rdy;
        leg = model_legal(cls, op, imm);
        w   = model_word(cls, op, rd, rs1, rs2, imm);
        @(posedge clk_i);
        #1;
        if (rst) begin
            q.delete();
            exp_cnt = 0;
            exp_err = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            exp_err = acc && !leg;
            if (acc && leg) q.push_back(w);
            if (exp_err && exp_cnt < 255) exp_cnt++;
        end
        chk("level", 32'(level_o), 32'(q.size()));
        chk("instr_valid", 32'(instr_valid_o), 32'(q.size() > 0));
        chk("instr", instr_o, (q.size() > 0) ? q[0] : 32'h0);
        chk("err", 32'(err_o), 32'(exp_err));
        chk("err_cnt", 32'(err_cnt_o), 32'(exp_cnt));
        @(negedge clk_i);
    endtask

    task automatic idle(input bit rdy);
        cycle(1'b0, 1'b0, 0, 0, 0, 0, 0, 32'h0, rdy);
    endtask

    // Push one request with the head held, compare against a known-good word, then pop it
    task automatic push_known(input string tag, input int cls, input int op, input int rd,
                              input int rs1, input int rs2, input logic [31:0] imm,
                              input logic [31:0] golden);
        cycle(1'b0, 1'b1, cls, op, rd, rs1, rs2, imm, 1'b0);
        chk(tag, instr_o, golden);
        idle(1'b1);
    endtask

    initial begin
        logic [31:0] rimm;
        @(negedge clk_i);
        cycle(1'b1, 1'b0, 0, 0, 0, 0, 0, 32'h0, 1'b0);
        cycle(1'b1, 1'b0, 0, 0, 0, 0, 0, 32'h0, 1'b0);
        chk("reset_level", 32'(level_o), 32'h0);
        chk("reset_instr", instr_o, 32'h0);
        idle(1'b0);

        push_known("add", 0, 0, 3, 1, 2, 32'h0, 32'h002081B3);
        push_known("sub", 0, 1, 5, 6, 7, 32'h0, 32'h407302B3);
        push_known("addi_m1", 1, 0, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFF00093);
        push_known("beq", 4, 0, 0, 1, 2, 32'd8, 32'h00208463);
        push_known("lui", 5, 0, 1, 0, 0, 32'h12345000, 32'h123450B7);
`ifdef RV32I_ENC_IMM_CHECK_EN
        cycle(1'b0, 1'b1, 1, 0, 0, 0, 0, 32'h800, 1'b0);
        chk("addi_800_err", 32'(err_o), 32'h1);
`else
        push_known("addi_800", 1, 0, 0, 0, 0, 32'h800, 32'h80000013);
`endif

        // Fill with consumer stalled; fifth request must be held
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 0, i, i + 1, i + 2, i + 3, 32'h0, 1'b0);
        chk("full_level", 32'(level_o), 32'd4);
        chk("full_ready", 32'(req_ready_o), 32'h0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b1, 0, 4, 5, 6, 7, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1);
        chk("drained", 32'(level_o), 32'h0);

        cycle(1'b0, 1'b1, 2, 3, 1, 1, 0, 32'h0, 1'b0);
        chk("load_f3_011_err", 32'(err_o), 32'h1);
        chk("load_f3_011_cnt", 32'(err_cnt_o), 32'h1);
        for (int i = 0; i < 256; i++) cycle(1'b0, 1'b1, 7, 0, 0, 0, 0, 32'h0, 1'b0);
        chk("err_cnt_sat", 32'(err_cnt_o), 32'hFF);

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 5, 0, i, 0, 0, 32'h0000_1000 * i, 1'b0);
        chk("pre_rst_level", 32'(level_o), 32'd3);
        cycle(1'b1, 1'b0, 0, 0, 0, 0, 0, 32'h0, 1'b0);
        chk("rst_level", 32'(level_o), 32'h0);
        chk("rst_valid", 32'(instr_valid_o), 32'h0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       rimm = 32'($urandom_range(0, 4095)) - 32'd2048;
                1:       rimm = 32'($urandom_range(0, 31));
                2:       rimm = $urandom & 32'hFFFF_F000;
                default: rimm = $urandom;
            endcase
            cycle(1'b0, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
                  int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), rimm,
                  1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
